// File: rtl/rv32_timer_pkg.sv
// Shared types, reset constants and the byte-lane merge helper for the machine timer.
`include "rv32_timer_regs.sv"

package rv32_timer_pkg;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        OFF_MTIME_LO    = `RV32_TIMER_OFF_MTIME_LO,
        OFF_MTIME_HI    = `RV32_TIMER_OFF_MTIME_HI,
        OFF_MTIMECMP_LO = `RV32_TIMER_OFF_MTIMECMP_LO,
        OFF_MTIMECMP_HI = `RV32_TIMER_OFF_MTIMECMP_HI,
        OFF_CTRL        = `RV32_TIMER_OFF_CTRL,
        OFF_STATUS      = `RV32_TIMER_OFF_STATUS,
        OFF_UNMAPPED6   = `RV32_TIMER_OFF_UNMAPPED6,
        OFF_UNMAPPED7   = `RV32_TIMER_OFF_UNMAPPED7
    } reg_off_e;

    // Byte n of the result comes from new_val when mask[n] is set, else from old_val.
    function automatic logic [31:0] apply_mask(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = mask[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/rv32_prescaler.sv
// Prescaler for the machine timer: emits a tick every (prescale + 1) enabled cycles.
module rv32_prescaler #(
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic                      clear_i,
    output logic                      tick_o
);

    logic [PRESCALE_WIDTH-1:0] pcnt_q;
    logic [PRESCALE_WIDTH-1:0] pcnt_d;

    // Tick decode and next count; a clear (CTRL write) takes priority over counting.
    always_comb begin
        tick_o = enable_i && (pcnt_q == prescale_i);
        pcnt_d = pcnt_q;
        if (clear_i) begin
            pcnt_d = {PRESCALE_WIDTH{1'b0}};
        end else if (tick_o) begin
            pcnt_d = {PRESCALE_WIDTH{1'b0}};
        end else if (enable_i) begin
            pcnt_d = pcnt_q + PRESCALE_WIDTH'(1);
        end else begin
            pcnt_d = pcnt_q;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= {PRESCALE_WIDTH{1'b0}};
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/rv32_timer_regs.sv
// Register offsets and CTRL bit positions for the machine timer window,
// shared with the bus decoder and the software headers.
`ifndef RV32_TIMER_REGS_SV
`define RV32_TIMER_REGS_SV
`define RV32_TIMER_OFF_MTIME_LO      3'd0
`define RV32_TIMER_OFF_MTIME_HI      3'd1
`define RV32_TIMER_OFF_MTIMECMP_LO   3'd2
`define RV32_TIMER_OFF_MTIMECMP_HI   3'd3
`define RV32_TIMER_OFF_CTRL          3'd4
`define RV32_TIMER_OFF_STATUS        3'd5
`define RV32_TIMER_OFF_UNMAPPED6     3'd6
`define RV32_TIMER_OFF_UNMAPPED7     3'd7
`define RV32_TIMER_CTRL_ENABLE_BIT   0
`define RV32_TIMER_CTRL_PRESCALE_LSB 8
`endif

// File: rtl/rv32_timer.sv
// Machine timer responder: 64-bit mtime/mtimecmp, CTRL/STATUS, zero-wait-state
// data-bus access and a registered level interrupt.
`include "rv32_timer_regs.sv"

module rv32_timer
    import rv32_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel_in,
    input  logic [31:0] address_in,
    input  logic        read_in,
    input  logic        write_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        fault_out,
    output logic        timer_irq_out
);

    logic [63:0]               mtime_q, mtime_d;
    logic [63:0]               mtimecmp_q, mtimecmp_d;
    logic                      enable_q, enable_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic                      irq_q;

    reg_off_e    offset_s;
    logic        active_s, fault_s, wr_en_s, ctrl_wr_s, pending_s, tick_s;
    logic [31:0] ctrl_word_s, ctrl_new_s, reg_rd_s;
    logic        unused_addr_s;

    assign offset_s      = reg_off_e'(address_in[4:2]);
    assign unused_addr_s = ^{address_in[31:5], address_in[1:0]};

    rv32_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .enable_i  (enable_q),
        .prescale_i(prescale_q),
        .clear_i   (ctrl_wr_s),
        .tick_o    (tick_s)
    );

    // Bus decode, fault detection and read mux.
    always_comb begin
        active_s    = sel_in && (read_in || write_in);
        pending_s   = (mtime_q >= mtimecmp_q);
        ctrl_word_s = 32'd0;
        ctrl_word_s[`RV32_TIMER_CTRL_ENABLE_BIT] = enable_q;
        ctrl_word_s[`RV32_TIMER_CTRL_PRESCALE_LSB +: PRESCALE_WIDTH] = prescale_q;
        fault_s  = 1'b0;
        reg_rd_s = 32'd0;
        case (offset_s)
            OFF_MTIME_LO:    reg_rd_s = mtime_q[31:0];
            OFF_MTIME_HI:    reg_rd_s = mtime_q[63:32];
            OFF_MTIMECMP_LO: reg_rd_s = mtimecmp_q[31:0];
            OFF_MTIMECMP_HI: reg_rd_s = mtimecmp_q[63:32];
            OFF_CTRL:        reg_rd_s = ctrl_word_s;
            OFF_STATUS: begin
                reg_rd_s = {31'd0, pending_s};
                fault_s  = active_s && write_in;
            end
            default:         fault_s = active_s;
        endcase
        fault_out      = fault_s;
        read_value_out = (active_s && read_in && !fault_s) ? reg_rd_s : 32'd0;
        wr_en_s        = active_s && write_in && !fault_s && (write_mask_in != 4'd0);
        ctrl_new_s     = apply_mask(ctrl_word_s, write_value_in, write_mask_in);
    end

    // Next state: an MTIME write replaces the increment for the whole 64 bits.
    always_comb begin
        mtime_d    = tick_s ? (mtime_q + 64'd1) : mtime_q;
        mtimecmp_d = mtimecmp_q;
        enable_d   = enable_q;
        prescale_d = prescale_q;
        ctrl_wr_s  = 1'b0;
        if (wr_en_s) begin
            case (offset_s)
                OFF_MTIME_LO:
                    mtime_d = {mtime_q[63:32], apply_mask(mtime_q[31:0], write_value_in, write_mask_in)};
                OFF_MTIME_HI:
                    mtime_d = {apply_mask(mtime_q[63:32], write_value_in, write_mask_in), mtime_q[31:0]};
                OFF_MTIMECMP_LO:
                    mtimecmp_d = {mtimecmp_q[63:32], apply_mask(mtimecmp_q[31:0], write_value_in, write_mask_in)};
                OFF_MTIMECMP_HI:
                    mtimecmp_d = {apply_mask(mtimecmp_q[63:32], write_value_in, write_mask_in), mtimecmp_q[31:0]};
                OFF_CTRL: begin
                    ctrl_wr_s  = 1'b1;
                    enable_d   = ctrl_new_s[`RV32_TIMER_CTRL_ENABLE_BIT];
                    prescale_d = ctrl_new_s[`RV32_TIMER_CTRL_PRESCALE_LSB +: PRESCALE_WIDTH];
                end
                default: ctrl_wr_s = 1'b0;
            endcase
        end else begin
            ctrl_wr_s = 1'b0;
        end
    end

    // State registers; reset overrides any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= MTIMECMP_RESET;
            enable_q   <= 1'b0;
            prescale_q <= {PRESCALE_WIDTH{1'b0}};
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            enable_q   <= enable_d;
            prescale_q <= prescale_d;
            irq_q      <= pending_s && enable_q;
        end
    end

    assign timer_irq_out = irq_q;

endmodule

// File: tb/tb_rv32_timer.sv
// Directed bench for rv32_timer: bus access, counting, wrap, compare interrupt and faults.
module tb_rv32_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel_in, read_in, write_in;
    logic [31:0] address_in, write_value_in;
    logic [3:0]  write_mask_in;
    logic [31:0] read_value_out;
    logic        fault_out, timer_irq_out;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [2:0] MLO = 3'd0, MHI = 3'd1, CLO = 3'd2, CHI = 3'd3,
                           CTRL = 3'd4, STAT = 3'd5, UM6 = 3'd6, UM7 = 3'd7;

    rv32_timer #(.PRESCALE_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .sel_in        (sel_in),
        .address_in    (address_in),
        .read_in       (read_in),
        .write_in      (write_in),
        .write_mask_in (write_mask_in),
        .write_value_in(write_value_in),
        .read_value_out(read_value_out),
        .fault_out     (fault_out),
        .timer_irq_out (timer_irq_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        sel_in = 1'b0; read_in = 1'b0; write_in = 1'b0;
        address_in = 32'd0; write_value_in = 32'd0; write_mask_in = 4'd0;
    endtask

    task automatic bus_write(input logic [2:0] off, input logic [31:0] val,
                             input logic [3:0] mask, output logic flt);
        @(negedge clk);
        sel_in = 1'b1; write_in = 1'b1;
        address_in = BASE | {27'd0, off, 2'b00};
        write_value_in = val; write_mask_in = mask;
        #1 flt = fault_out;
        @(posedge clk);
        #1 idle();
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] val);
        logic f;
        bus_write(off, val, 4'hF, f);
    endtask

    // Combinational read at the current time; does not cross a clock edge.
    task automatic bus_read(input logic [2:0] off, input logic sel,
                            output logic [31:0] d, output logic flt);
        sel_in = sel; read_in = 1'b1;
        address_in = BASE | {27'd0, off, 2'b00};
        #1 d = read_value_out; flt = fault_out;
        idle();
    endtask

    task automatic chk_rd(input string tag, input logic [2:0] off, input logic [31:0] exp);
        logic [31:0] d;
        logic f;
        bus_read(off, 1'b1, d, f);
        check(tag, d, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic f;
        idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("idle_rdata", read_value_out, 32'd0);
        check("idle_fault", {31'd0, fault_out}, 32'd0);
        check("rst_irq", {31'd0, timer_irq_out}, 32'd0);
        chk_rd("rst_mtime_lo", MLO, 32'd0);
        chk_rd("rst_cmp_hi", CHI, 32'hFFFF_FFFF);
        chk_rd("rst_ctrl", CTRL, 32'd0);
        chk_rd("rst_status", STAT, 32'd0);

        // 1: prescale 0, ten ticks
        wr(CTRL, 32'h1);
        repeat (10) @(posedge clk);
        #1 chk_rd("t1_mtime10", MLO, 32'd10);
        check("t1_irq", {31'd0, timer_irq_out}, 32'd0);
        wr(CTRL, 32'h0);
        chk_rd("t1_disable_edge", MLO, 32'd11);
        repeat (5) @(posedge clk);
        #1 chk_rd("t1_frozen", MLO, 32'd11);

        // 2: prescale 3 -> one tick per 4 cycles
        wr(CTRL, 32'h0301);
        chk_rd("t2_ctrl", CTRL, 32'h0000_0301);
        repeat (3) @(posedge clk);
        #1 chk_rd("t2_before_tick", MLO, 32'd11);
        @(posedge clk);
        #1 chk_rd("t2_tick1", MLO, 32'd12);
        repeat (4) @(posedge clk);
        #1 chk_rd("t2_tick2", MLO, 32'd13);
        wr(CTRL, 32'h0300);
        repeat (5) @(posedge clk);
        #1 chk_rd("t2_frozen", MLO, 32'd13);

        // 3: carry into HI, full wrap, write wins over increment
        wr(MLO, 32'hFFFF_FFFF);
        wr(MHI, 32'h0);
        wr(CTRL, 32'h1);
        @(posedge clk);
        #1 chk_rd("t3_carry_lo", MLO, 32'd0);
        chk_rd("t3_carry_hi", MHI, 32'd1);
        wr(CTRL, 32'h0);
        wr(MHI, 32'hFFFF_FFFF);
        wr(MLO, 32'hFFFF_FFFF);
        wr(CTRL, 32'h1);
        @(posedge clk);
        #1 chk_rd("t3_wrap_lo", MLO, 32'd0);
        chk_rd("t3_wrap_hi", MHI, 32'd0);
        wr(MLO, 32'h55);
        chk_rd("t3_write_wins", MLO, 32'h55);
        chk_rd("t3_no_carry", MHI, 32'd0);
        wr(CTRL, 32'h0);

        // Reset overrides a write presented in the same cycle
        @(negedge clk);
        reset = 1'b1;
        sel_in = 1'b1; write_in = 1'b1; address_in = BASE;
        write_value_in = 32'h1234; write_mask_in = 4'hF;
        @(posedge clk);
        #1 idle();
        reset = 1'b0;
        chk_rd("rst_over_write", MLO, 32'd0);
        chk_rd("rst_ctrl2", CTRL, 32'd0);

        // 4: compare interrupt
        wr(CLO, 32'd20);
        wr(CHI, 32'd0);
        wr(CTRL, 32'h1);
        repeat (19) @(posedge clk);
        #1 chk_rd("t4_status_19", STAT, 32'd0);
        @(posedge clk);
        #1 chk_rd("t4_status_20", STAT, 32'd1);
        check("t4_irq_lag", {31'd0, timer_irq_out}, 32'd0);
        @(posedge clk);
        #1 check("t4_irq_rise", {31'd0, timer_irq_out}, 32'd1);
        wr(CHI, 32'd1);
        check("t4_irq_still", {31'd0, timer_irq_out}, 32'd1);
        chk_rd("t4_status_clr", STAT, 32'd0);
        @(posedge clk);
        #1 check("t4_irq_fall", {31'd0, timer_irq_out}, 32'd0);

        // 5: byte-lane write and zero mask
        bus_write(CLO, 32'h00AB_0000, 4'b0100, f);
        chk_rd("t5_byte2", CLO, 32'h00AB_0014);
        bus_write(CLO, 32'hFFFF_FFFF, 4'b0000, f);
        check("t5_mask0_fault", {31'd0, f}, 32'd0);
        chk_rd("t5_mask0_hold", CLO, 32'h00AB_0014);

        // 6: faults and deselected access
        wr(CTRL, 32'h0);
        bus_read(UM6, 1'b1, d, f);
        check("t6_um6_fault", {31'd0, f}, 32'd1);
        check("t6_um6_data", d, 32'd0);
        bus_write(STAT, 32'hFFFF_FFFF, 4'hF, f);
        check("t6_wstat_fault", {31'd0, f}, 32'd1);
        bus_write(UM7, 32'hFFFF_FFFF, 4'hF, f);
        check("t6_um7_fault", {31'd0, f}, 32'd1);
        bus_read(CLO, 1'b0, d, f);
        check("t6_nosel_fault", {31'd0, f}, 32'd0);
        check("t6_nosel_data", d, 32'd0);
        chk_rd("t6_cmp_lo_kept", CLO, 32'h00AB_0014);
        chk_rd("t6_cmp_hi_kept", CHI, 32'd1);
        chk_rd("t6_mtime_kept", MLO, 32'd26);

        // STATUS pending is not gated by enable; irq is
        wr(CHI, 32'd0);
        wr(CLO, 32'd0);
        chk_rd("t7_status_ungated", STAT, 32'd1);
        repeat (2) @(posedge clk);
        #1 check("t7_irq_gated", {31'd0, timer_irq_out}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
